mux_scan_ctrl: RTL and testbench



---
 rtl/mux_scan_ctrl.sv | 117 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin select sequencer and sampler for a 4:1 mux.
// Walks the select lines {s1,s0} over every enabled channel in ascending
// order. Each select is held for SETTLE+1 cycles, then the mux output y is
// captured into that channel's bit of the sample register.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1  // extra hold cycles per channel, 0..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] mask,
  input  logic       y,
  output logic       s1,
  output logic       s0,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t     state;
  logic [3:0] mask_q;
  logic [1:0] ch;
  logic [3:0] cnt;

  logic [1:0] first_ch;
  logic [1:0] next_ch;
  logic       has_next;

  // Lowest enabled channel of the incoming mask, and the next enabled
  // channel strictly above the current one in the latched mask.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    first_ch = 2'd0;
    next_ch  = ch;
    has_next = 1'b0;
    // Descending loop: the last match written wins, i.e. the lowest one.
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) begin
        first_ch = 2'(k);
      end
      if (mask_q[k] && (2'(k) > ch)) begin
        next_ch  = 2'(k);
        has_next = 1'b1;
      end
    end
  end

  // Scan sequencer: state, select, settle counter and result capture.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignment so every branch
    // reads the pre-edge values, matching the hardware registers.
    if (rst) begin
      state  <= IDLE;
      mask_q <= 4'b0000;
      ch     <= 2'd0;
      cnt    <= 4'd0;
      s1     <= 1'b0;
      s0     <= 1'b0;
      sample <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sample <= 4'b0000;
            if (mask != 4'b0000) begin
              mask_q    <= mask;
              ch        <= first_ch;
              {s1, s0}  <= first_ch;
              cnt       <= 4'd0;
              state     <= SCAN;
            end else begin
              state <= DONE;
            end
          end
        end

        SCAN: begin
          if (cnt != SETTLE_C) begin
            cnt <= cnt + 4'd1;
          end else begin
            sample[ch] <= y;
            cnt        <= 4'd0;
            if (has_next) begin
              ch       <= next_ch;
              {s1, s0} <= next_ch;
            end else begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          {s1, s0} <= 2'b00;
          state    <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status flags decode straight from the state register.
  assign busy = (state == SCAN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Testbench for mux_scan_ctrl (SETTLE=1) driving a behavioural 4:1 mux.
// A queue-based schedule model predicts s1/s0/busy/done/sample each cycle;
// directed scenarios add literal expectations that pin the model itself.
module tb_mux_scan_ctrl;

  localparam int SETTLE = 1;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] mask;
  logic [3:0] i;     // mux data inputs i3..i0
  logic       y;
  logic       s1, s0, busy, done;
  logic [3:0] sample;

  int n_pass  = 0;
  int n_total = 0;

  mux_scan_ctrl #(.SETTLE(SETTLE)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mask   (mask),
    .y      (y),
    .s1     (s1),
    .s0     (s0),
    .busy   (busy),
    .done   (done),
    .sample (sample)
  );

  // The k-map mux: combinational from the DUT's select lines.
  assign y = i[{s1, s0}];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------
  // Reference model: on an accepted start, the whole scan is planned as a
  // list of per-edge steps; each edge pops one step. Empty list == idle.
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic       cap;    // capture the mux output of channel ch at this edge
    logic [1:0] ch;
    logic [1:0] sel;    // select value after this edge
    logic       busy;
    logic       done;
  } step_t;

  step_t      plan[$];
  int         chans[$];
  logic [1:0] m_sel;
  logic       m_busy, m_done, m_valid;
  logic [3:0] m_sample;

  initial m_valid = 1'b0;

  always @(posedge clk) begin : model
    step_t st;
    logic  last;
    if (rst) begin
      plan.delete();
      m_sel = 2'b00; m_busy = 1'b0; m_done = 1'b0; m_sample = 4'b0000;
      m_valid = 1'b1;
    end else if (plan.size() > 0) begin
      st = plan.pop_front();
      if (st.cap) m_sample[st.ch] = i[st.ch];
      m_sel = st.sel; m_busy = st.busy; m_done = st.done;
    end else if (start) begin
      chans.delete();
      for (int k = 0; k < 4; k++) if (mask[k]) chans.push_back(k);
      m_sample = 4'b0000;
      if (chans.size() == 0) begin
        m_sel = 2'b00; m_busy = 1'b0; m_done = 1'b1;
      end else begin
        m_sel = 2'(chans[0]); m_busy = 1'b1; m_done = 1'b0;
        for (int j = 0; j < chans.size(); j++) begin
          last = (j == chans.size() - 1);
          for (int c = 0; c < SETTLE; c++) begin
            st = '0; st.sel = 2'(chans[j]); st.busy = 1'b1;
            plan.push_back(st);
          end
          st = '0;
          st.cap  = 1'b1;
          st.ch   = 2'(chans[j]);
          st.sel  = last ? 2'(chans[j]) : 2'(chans[j + 1]);
          st.busy = !last;
          st.done = last;
          plan.push_back(st);
        end
      end
      // Final step: the done cycle returns to idle with select 00.
      plan.push_back('0);
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(posedge clk) begin
    #1;
    if (m_valid)
      check("cycle", {8'h00, s1, s0, busy, done, sample},
                     {8'h00, m_sel, m_busy, m_done, m_sample});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check(name, {15'd0, done}, 16'd1);
  endtask

  // Start a 4-channel scan and record 8 cycles of select/busy. Optionally
  // disturb start/mask mid-scan, or keep start high throughout.
  task automatic full_scan(input bit disturb, input bit hold,
                           output logic [15:0] sels, output int bcount);
    mask = 4'b1111; start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    sels = '0; bcount = 0;
    for (int k = 0; k < 8; k++) begin
      sels = {sels[13:0], s1, s0};
      bcount += int'(busy);
      if (disturb && k == 3) begin start = 1'b1; mask = 4'b0001; end
      if (disturb && k == 4) begin start = 1'b0; end
      tick();
    end
    mask = 4'b1111;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] sels;
    int          bcount, dcount, n;

    rst = 1'b1; start = 1'(($urandom)); mask = 4'($urandom); i = 4'b1101;
    // Reset with random start/mask.
    tick();
    start = 1'($urandom); mask = 4'($urandom);
    tick();
    check("reset", {8'h00, s1, s0, busy, done, sample}, 16'h0000);
    rst = 1'b0; start = 1'b0;
    tick();

    // Full scan: i0=1 i1=0 i2=1 i3=1.
    i = 4'b1101;
    full_scan(1'b0, 1'b0, sels, bcount);
    check("full_sels", sels, 16'b00_00_01_01_10_10_11_11);
    check("full_busy_cycles", 16'(bcount), 16'd8);
    check("full_done", {14'd0, busy, done}, 16'b01);
    check("full_sample", {12'd0, sample}, 16'h000d);
    tick();
    check("full_done_pulse", {15'd0, done}, 16'd0);

    // Ignored start/mask changes mid-scan.
    full_scan(1'b1, 1'b0, sels, bcount);
    check("ign_sels", sels, 16'b00_00_01_01_10_10_11_11);
    check("ign_done", {14'd0, busy, done}, 16'b01);
    check("ign_sample", {12'd0, sample}, 16'h000d);
    tick();

    // Sparse mask 1010 with i1=0, i3=1.
    i = {1'b1, 1'($urandom), 1'b0, 1'($urandom)};
    mask = 4'b1010; start = 1'b1;
    tick();
    start = 1'b0;
    sels = '0; bcount = 0;
    for (int k = 0; k < 4; k++) begin
      sels = {sels[13:0], s1, s0};
      bcount += int'(busy);
      tick();
    end
    check("sparse_sels", sels[7:0], 16'b01_01_11_11);
    check("sparse_busy_cycles", 16'(bcount), 16'd4);
    check("sparse_done", {14'd0, busy, done}, 16'b01);
    check("sparse_sample", {12'd0, sample}, 16'h0008);
    tick();

    // Empty mask: straight to done, busy never rises, sample cleared.
    mask = 4'b0000; start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_done", {11'd0, busy, done, sample}, 16'b0_1_0000);
    tick();
    check("empty_idle", {14'd0, busy, done}, 16'b00);

    // Start held high: next scan begins right after the idle cycle.
    i = 4'b1101;
    full_scan(1'b0, 1'b1, sels, bcount);
    check("hold_done", {14'd0, busy, done}, 16'b01);
    tick();
    check("hold_idle", {14'd0, busy, done}, 16'b00);
    tick();
    check("hold_restart", {12'd0, s1, s0, busy, done}, 16'b00_1_0);
    start = 1'b0;
    wait_done("hold_second_done");
    check("hold_second_sample", {12'd0, sample}, 16'h000d);
    tick();

    // Reset in the middle of a scan while select is 10.
    mask = 4'b1111; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while ({s1, s0} != 2'b10 && n < 20) begin tick(); n++; end
    check("abort_reach_sel2", {14'd0, s1, s0}, 16'b10);
    rst = 1'b1;
    tick();
    check("abort_reset", {8'h00, s1, s0, busy, done, sample}, 16'h0000);
    rst = 1'b0;
    dcount = 0;
    repeat (6) begin tick(); dcount += int'(done); end
    check("abort_no_done", 16'(dcount), 16'd0);
    i = 4'($urandom);
    mask = 4'b0101; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("abort_fresh_done");
    check("abort_fresh_sample", {12'd0, sample}, {12'd0, i & 4'b0101});
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(63) == 0);
      start = ($urandom_range(3) == 0);
      mask  = 4'($urandom);
      i     = 4'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
